// File: rtl/permutation_iter_pkg.sv
// Ascon state type and round constants, plus the control types of the
// self-sequencing permutation core.
package ascon_pack;

    localparam int PA_ROUNDS = 12;

    typedef logic [63:0] type_word;
    // Word 0 is x0, word 4 is x4.
    typedef type_word [4:0] type_state;

    // c_r = 0xF0 - 0x0F*r, i.e. 0xF0, 0xE1, ... 0x4B for r = 0..11.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return 8'hF0 - (8'h0F * {4'd0, r});
    endfunction

endpackage

package permutation_iter_pkg;

    import ascon_pack::*;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam logic [3:0] ROUND_LAST = 4'(PA_ROUNDS);

    // p^a starts at index 0; p^b ends on the same last index 11.
    function automatic logic [3:0] first_round(input logic mode, input int pb_rounds);
        return mode ? 4'(PA_ROUNDS - pb_rounds) : 4'd0;
    endfunction

endpackage

// File: rtl/permutation_iter_if.sv
// Start/done handshake and state bus between the mode FSM and the permutation core.
interface permutation_iter_if;

    import ascon_pack::*;

    logic      start_i;
    logic      mode_i;
    type_state state_i;
    logic      busy_o;
    logic      done_o;
    type_state state_o;

    modport master (
        output start_i,
        output mode_i,
        output state_i,
        input  busy_o,
        input  done_o,
        input  state_o
    );

    modport slave (
        input  start_i,
        input  mode_i,
        input  state_i,
        output busy_o,
        output done_o,
        output state_o
    );

endinterface

// File: rtl/permutation_iter_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    function automatic logic [63:0] ror(input logic [63:0] w, input int unsigned n);
        return (w >> n) | (w << (64 - n));
    endfunction

    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] s0, s1, s2, s3, s4;

    assign c0 = state_i[0];
    assign c1 = state_i[1];
    assign c2 = {state_i[2][63:8], state_i[2][7:0] ^ round_const(round_i)};
    assign c3 = state_i[3];
    assign c4 = state_i[4];

    // S-box as the 5-bit chi-like network applied to all 64 columns at once.
    assign a0 = c0 ^ c4;
    assign a1 = c1;
    assign a2 = c2 ^ c1;
    assign a3 = c3;
    assign a4 = c4 ^ c3;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign s0 = b0 ^ b4;
    assign s1 = b1 ^ b0;
    assign s2 = ~b2;
    assign s3 = b3 ^ b2;
    assign s4 = b4;

    assign state_o[0] = s0 ^ ror(s0, 19) ^ ror(s0, 28);
    assign state_o[1] = s1 ^ ror(s1, 61) ^ ror(s1, 39);
    assign state_o[2] = s2 ^ ror(s2, 1)  ^ ror(s2, 6);
    assign state_o[3] = s3 ^ ror(s3, 10) ^ ror(s3, 17);
    assign state_o[4] = s4 ^ ror(s4, 7)  ^ ror(s4, 41);

endmodule

// File: rtl/permutation_iter.sv
// Ascon permutation core with internal round counter; runs p^a or p^b
// on a start pulse and reports completion with a one-cycle done pulse.
module permutation_iter
    import ascon_pack::*;
    import permutation_iter_pkg::*;
#(
    parameter int UNROLL    = 1,
    parameter int PB_ROUNDS = 6
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    permutation_iter_if.slave bus
);

    if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
        $error("permutation_iter: UNROLL must be 1 or 2");
    end
    if (!(PB_ROUNDS == 6 || PB_ROUNDS == 8)) begin : g_bad_pb
        $error("permutation_iter: PB_ROUNDS must be 6 or 8");
    end

    localparam logic [3:0] STEP = 4'(UNROLL);

    fsm_t       fsm_q;
    logic [3:0] cnt_q;
    type_state  state_q;
    logic       busy_q;
    logic       done_q;

    logic [3:0] rbase;
    logic       last_step;
    type_state  chain [UNROLL+1];

    // While idle the datapath is pre-aimed at the incoming request, so the
    // accepting edge already applies the first UNROLL rounds.
    assign rbase     = (fsm_q == IDLE) ? first_round(bus.mode_i, PB_ROUNDS) : cnt_q;
    assign chain[0]  = (fsm_q == IDLE) ? bus.state_i : state_q;
    assign last_step = ((rbase + STEP) == ROUND_LAST);

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        ascon_round u_round (
            .state_i (chain[g]),
            .round_i (rbase + 4'(g)),
            .state_o (chain[g+1])
        );
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'd0;
            state_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q <= chain[UNROLL];
                        cnt_q   <= rbase + STEP;
                        if (last_step) begin
                            done_q <= 1'b1;
                        end else begin
                            fsm_q  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    state_q <= chain[UNROLL];
                    cnt_q   <= rbase + STEP;
                    if (last_step) begin
                        fsm_q  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state_o = state_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule
